gmem_port_arbiter: RTL and testbench

Shares one read port of `graph_memory` between several requesters, for example the neighbour/position fetch engine and the initial query-vertex loader of the best-first search. It arbitrates among valid requests, issues one memory read per cycle, and tracks outstanding reads in an in-order tag FIFO so each response is routed back to the requester that issued it. A flush handshake lets the search controller drain all in-flight reads before reconfiguring or restarting the search.

---
 rtl/gmem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_gmem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gmem_port_arbiter.sv
// Round-robin arbiter sharing one graph_memory read port, with an in-order tag FIFO for response
// routing and a flush/drain handshake. Define GMEM_ARB_PRIO0_EN to give requester 0 strict priority.
module gmem_port_arbiter #(
   parameter int unsigned NUM_REQ         = 3,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [NUM_REQ-1:0]    req_valid_in,
   input  logic [ADDR_WIDTH-1:0] req_addr_in [NUM_REQ],
   output logic [NUM_REQ-1:0]    req_ready_out,
   output logic [ADDR_WIDTH-1:0] mem_req_out,
   output logic                  mem_valid_out,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic                  mem_valid_in,
   output logic [DATA_WIDTH-1:0] resp_data_out,
   output logic [NUM_REQ-1:0]    resp_valid_out,
   input  logic                  flush_in,
   output logic                  flush_done_out,
   output logic                  busy_out,
   output logic                  error_out
);
   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  outstanding;
   logic [ID_W-1:0]   tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              grant_en;
   logic              grant_any;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   scan_id;
   logic              pop;
   logic [ID_W-1:0]   pop_tag;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Flush FSM: a flush request wins over any grant in the same cycle
   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
      case (state_q)
         RUN: begin
            if (flush_in) state_d = DRAIN;
            else          grant_en = rst_in && (outstanding < CNT_W'(MAX_OUTSTANDING));
         end
         DRAIN:   if (outstanding == '0) state_d = DONE;
         DONE:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Rotating search starting just past the last granted requester
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_id   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         scan_id = ID_W'((32'(rr_ptr) + 32'd1 + i) % NUM_REQ);
         if (!grant_any && req_valid_in[scan_id]) begin
            grant_any = 1'b1;
            grant_idx = scan_id;
         end
      end
`ifdef GMEM_ARB_PRIO0_EN
      if (req_valid_in[0]) begin
         grant_any = 1'b1;
         grant_idx = '0;
      end
`endif
      if (!grant_en) grant_any = 1'b0;
      req_ready_out = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
   end

   assign pop      = mem_valid_in && (outstanding != '0);
   assign pop_tag  = tag_mem[rd_ptr];
   assign busy_out = (outstanding != '0);

   always_ff @(posedge clk_in) begin
      if (grant_any) tag_mem[wr_ptr] <= grant_idx;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q        <= RUN;
         rr_ptr         <= ID_W'(NUM_REQ - 1);
         outstanding    <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         mem_req_out    <= '0;
         mem_valid_out  <= 1'b0;
         resp_data_out  <= '0;
         resp_valid_out <= '0;
         flush_done_out <= 1'b0;
         error_out      <= 1'b0;
      end else begin
         state_q        <= state_d;
         flush_done_out <= (state_d == DONE);
         mem_valid_out  <= grant_any;
         resp_valid_out <= '0;
         if (grant_any) begin
            mem_req_out <= req_addr_in[grant_idx];
            wr_ptr      <= ptr_inc(wr_ptr);
`ifdef GMEM_ARB_PRIO0_EN
            if (grant_idx != '0) rr_ptr <= grant_idx;
`else
            rr_ptr <= grant_idx;
`endif
         end
         if (pop) begin
            resp_data_out  <= mem_data_in;
            resp_valid_out <= NUM_REQ'(1) << pop_tag;
            rd_ptr         <= ptr_inc(rd_ptr);
         end
         // A response with nothing in flight is a protocol violation; latch it until reset
         if (mem_valid_in && (outstanding == '0)) error_out <= 1'b1;
         case ({grant_any, pop})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end
endmodule

// File: tb/tb_gmem_port_arbiter.sv
// Scoreboard bench for gmem_port_arbiter: stimulus queues expected memory reads and responses,
// a negedge monitor pops and compares them. Expectations follow GMEM_ARB_PRIO0_EN when defined.
`timescale 1ns/1ps
module tb_gmem_port_arbiter;
   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [2:0]  req_valid_in;
   logic [31:0] req_addr_in [3];
   logic [2:0]  req_ready_out;
   logic [31:0] mem_req_out;
   logic        mem_valid_out;
   logic [31:0] mem_data_in;
   logic        mem_valid_in;
   logic [31:0] resp_data_out;
   logic [2:0]  resp_valid_out;
   logic        flush_in;
   logic        flush_done_out;
   logic        busy_out;
   logic        error_out;

   gmem_port_arbiter #(
      .NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req_valid_in(req_valid_in), .req_addr_in(req_addr_in), .req_ready_out(req_ready_out),
      .mem_req_out(mem_req_out), .mem_valid_out(mem_valid_out),
      .mem_data_in(mem_data_in), .mem_valid_in(mem_valid_in),
      .resp_data_out(resp_data_out), .resp_valid_out(resp_valid_out),
      .flush_in(flush_in), .flush_done_out(flush_done_out),
      .busy_out(busy_out), .error_out(error_out)
   );

   always #5 clk_in = ~clk_in;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   logic [31:0] exp_addr_q [$];
   logic [2:0]  exp_rsp_q  [$];
   logic [31:0] exp_data_q [$];

   logic [2:0]  fair_g  [6];
   logic [2:0]  sat_rdy [13];
   logic [2:0]  sat_rsp [13];
   logic [2:0]  g_resume;
   logic [1:0]  fd_exp  [8];
   logic [2:0]  t_rdy, t_rsp, t_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle, check the combinational grant, queue the expected effects
   task automatic cyc(input logic [2:0] v, input logic fl, input logic mv, input logic [31:0] md,
                      input logic [2:0] exp_rdy, input logic [2:0] exp_rsp);
      req_valid_in = v;
      flush_in     = fl;
      mem_valid_in = mv;
      mem_data_in  = md;
      #1;
      check("req_ready", 32'(req_ready_out), 32'(exp_rdy));
      for (int i = 0; i < 3; i++)
         if (exp_rdy[i]) exp_addr_q.push_back(req_addr_in[i]);
      if (exp_rsp != 3'b000) begin
         exp_rsp_q.push_back(exp_rsp);
         exp_data_q.push_back(md);
      end
      @(negedge clk_in);
   endtask

   task automatic check_reset_outputs();
      check("rst_ready",     32'(req_ready_out),  32'd0);
      check("rst_mem_valid", 32'(mem_valid_out),  32'd0);
      check("rst_mem_req",   mem_req_out,         32'd0);
      check("rst_resp_vld",  32'(resp_valid_out), 32'd0);
      check("rst_resp_data", resp_data_out,       32'd0);
      check("rst_flush_done",32'(flush_done_out), 32'd0);
      check("rst_busy",      32'(busy_out),       32'd0);
      check("rst_error",     32'(error_out),      32'd0);
   endtask

   always @(negedge clk_in) begin
      if (mem_valid_out === 1'b1) begin
         if (exp_addr_q.size() == 0) check("mem_unexpected", 32'(mem_valid_out), 32'd0);
         else check("mem_addr", mem_req_out, exp_addr_q.pop_front());
      end
      if (resp_valid_out !== 3'b000) begin
         if (exp_rsp_q.size() == 0) check("resp_unexpected", 32'(resp_valid_out), 32'd0);
         else begin
            check("resp_id", 32'(resp_valid_out), 32'(exp_rsp_q.pop_front()));
            check("resp_data", resp_data_out, exp_data_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef GMEM_ARB_PRIO0_EN
      fair_g   = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
      sat_rdy  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001,
                   3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
      sat_rsp  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000,
                   3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
      g_resume = 3'b001;
`else
      fair_g   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      sat_rdy  = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b001,
                   3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
      sat_rsp  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000,
                   3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
      g_resume = 3'b010;
`endif
      fd_exp = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
      rst_in = 1'b0;
      req_valid_in = 3'b000;
      flush_in = 1'b0;
      mem_valid_in = 1'b0;
      mem_data_in = 32'd0;
      req_addr_in[0] = 32'h00;
      req_addr_in[1] = 32'h10;
      req_addr_in[2] = 32'h20;

      // reset holds grants off even with requests pending
      @(negedge clk_in);
      req_valid_in = 3'b111;
      #1;
      check_reset_outputs();
      @(negedge clk_in);
      rst_in = 1'b1;
      req_valid_in = 3'b000;

      // fairness, memory latency 1
      for (int i = 0; i < 8; i++) begin
         check("fair_busy", 32'(busy_out), (i == 0) ? 32'd0 : 32'd1);
         t_v   = (i < 6) ? 3'b111 : 3'b000;
         t_rdy = 3'b000;
         t_rsp = 3'b000;
         if (i < 6)  t_rdy = fair_g[i];
         if (i >= 2) t_rsp = fair_g[i-2];
         cyc(t_v, 1'b0, (i >= 2), 32'(32'hA0 + i), t_rdy, t_rsp);
      end
      check("fair_idle_busy", 32'(busy_out), 32'd0);

      // single request, memory latency 2
      cyc(3'b010, 1'b0, 1'b0, 32'd0, 3'b010, 3'b000);
      check("single_busy", 32'(busy_out), 32'd1);
      cyc(3'b000, 1'b0, 1'b0, 32'd0, 3'b000, 3'b000);
      cyc(3'b000, 1'b0, 1'b0, 32'd0, 3'b000, 3'b000);
      cyc(3'b000, 1'b0, 1'b1, 32'hAB, 3'b000, 3'b010);
      check("single_busy_clr", 32'(busy_out), 32'd0);

      // saturation at four outstanding; freed slot usable one cycle later
      for (int i = 0; i < 13; i++) begin
         check("sat_busy", 32'(busy_out), (i >= 1 && i <= 11) ? 32'd1 : 32'd0);
         t_v = (i <= 7) ? 3'b111 : 3'b000;
         cyc(t_v, 1'b0, (sat_rsp[i] != 3'b000), 32'(32'hD0 + i), sat_rdy[i], sat_rsp[i]);
      end

      // in-order routing
      cyc(3'b100, 1'b0, 1'b0, 32'd0, 3'b100, 3'b000);
      cyc(3'b001, 1'b0, 1'b0, 32'd0, 3'b001, 3'b000);
      cyc(3'b010, 1'b0, 1'b0, 32'd0, 3'b010, 3'b000);
      cyc(3'b000, 1'b0, 1'b0, 32'd0, 3'b000, 3'b000);
      cyc(3'b000, 1'b0, 1'b1, 32'h1, 3'b000, 3'b100);
      cyc(3'b000, 1'b0, 1'b1, 32'h2, 3'b000, 3'b001);
      cyc(3'b000, 1'b0, 1'b1, 32'h3, 3'b000, 3'b010);
      cyc(3'b000, 1'b0, 1'b0, 32'd0, 3'b000, 3'b000);

      // flush with three reads in flight
      cyc(3'b001, 1'b0, 1'b0, 32'd0, 3'b001, 3'b000);
      cyc(3'b010, 1'b0, 1'b0, 32'd0, 3'b010, 3'b000);
      cyc(3'b100, 1'b0, 1'b0, 32'd0, 3'b100, 3'b000);
      check("fl_done_3", 32'(flush_done_out), 32'd0);
      cyc(3'b111, 1'b1, 1'b0, 32'd0, 3'b000, 3'b000);
      cyc(3'b111, 1'b0, 1'b1, 32'h51, 3'b000, 3'b001);
      cyc(3'b111, 1'b0, 1'b1, 32'h52, 3'b000, 3'b010);
      check("fl_done_6", 32'(flush_done_out), 32'd0);
      cyc(3'b111, 1'b0, 1'b1, 32'h53, 3'b000, 3'b100);
      check("fl_done_7", 32'(flush_done_out), 32'd0);
      cyc(3'b111, 1'b0, 1'b0, 32'd0, 3'b000, 3'b000);
      check("fl_done_8", 32'(flush_done_out), 32'd1);
      cyc(3'b111, 1'b0, 1'b0, 32'd0, 3'b000, 3'b000);
      check("fl_done_9", 32'(flush_done_out), 32'd0);
      cyc(3'b111, 1'b0, 1'b0, 32'd0, 3'b001, 3'b000);
      cyc(3'b000, 1'b0, 1'b0, 32'd0, 3'b000, 3'b000);
      cyc(3'b000, 1'b0, 1'b1, 32'h54, 3'b000, 3'b001);

      // flush held high through DONE re-enters drain
      for (int i = 0; i < 8; i++) begin
         check("fl2_done", 32'(flush_done_out), 32'(fd_exp[i]));
         if (i < 6)       cyc(3'b111, (i < 4), 1'b0, 32'd0, 3'b000, 3'b000);
         else if (i == 6) cyc(3'b111, 1'b0, 1'b0, 32'd0, g_resume, 3'b000);
         else             cyc(3'b000, 1'b0, 1'b0, 32'd0, 3'b000, 3'b000);
      end
      cyc(3'b000, 1'b0, 1'b1, 32'h61, 3'b000, g_resume);

      // response with nothing outstanding, then reset mid-operation
      check("err_before", 32'(error_out), 32'd0);
      cyc(3'b000, 1'b0, 1'b1, 32'hEE, 3'b000, 3'b000);
      check("err_set", 32'(error_out), 32'd1);
      check("err_resp_data_kept", resp_data_out, 32'h61);
      cyc(3'b100, 1'b0, 1'b0, 32'd0, 3'b100, 3'b000);
      rst_in = 1'b0;
      req_valid_in = 3'b111;
      mem_valid_in = 1'b0;
      #1;
      check("rst_mid_ready", 32'(req_ready_out), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      req_valid_in = 3'b000;
      #1;
      check_reset_outputs();
      cyc(3'b000, 1'b0, 1'b1, 32'h77, 3'b000, 3'b000);
      check("err_after_rst", 32'(error_out), 32'd1);
      cyc(3'b000, 1'b0, 1'b0, 32'd0, 3'b000, 3'b000);

      check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
      check("rsp_q_empty",  32'(exp_rsp_q.size()),  32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
